// File: rtl/vdp_vram_pkg.sv
// Shared types and helpers for the VDP VRAM slot arbiter: slot owners,
// dot-phase encodings and the interleaved address mapping.
package vdp_vram_pkg;

  localparam int VRAM_ADR_W = 17;

  // DOTSTATE walks 00 -> 01 -> 11 -> 10, one step per CLK21M cycle
  localparam logic [1:0] DS_PH0 = 2'b00;
  localparam logic [1:0] DS_PH1 = 2'b01;
  localparam logic [1:0] DS_PH2 = 2'b11;
  localparam logic [1:0] DS_PH3 = 2'b10;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SP_RD  = 3'd1,
    CPU_RD = 3'd2,
    CPU_WR = 3'd3,
    WAIT   = 3'd4
  } slot_owner_t;

  // Interleave rotates the low w bits right by one: {adr[0], adr[w-1:1]}.
  // The caller zero-extends to 32 bits and truncates the result back to w.
  function automatic logic [31:0] vram_interleave(input logic [31:0] adr,
                                                  input logic        mode,
                                                  input int unsigned w);
    logic [31:0] r;
    r = adr;
    if (mode) r = (adr >> 1) | ({31'd0, adr[0]} << (w - 1));
    return r;
  endfunction

endpackage

// File: rtl/vdp_vram_sprite_port.sv
// One VRAM slot per dot, shared by the sprite engine (absolute priority) and a
// CPU port. CPU_REQ is a level held until the one-clock CPU_ACK pulse; after an
// ACK the port is not served again until CPU_REQ has been low for a full dot.
module vdp_vram_sprite_port
  import vdp_vram_pkg::*;
#(
  parameter int READ_LATENCY = 2,
  parameter int ADR_W        = VRAM_ADR_W
) (
  input  logic              CLK21M,
  input  logic              RESET,
  input  logic [1:0]        DOTSTATE,
  input  logic              VRAMINTERLEAVEMODE,
  input  logic              SPVRAMACCESSING,
  input  logic [ADR_W-1:0]  PRAMADR,
  output logic [7:0]        PRAMDAT,
  input  logic              CPU_REQ,
  input  logic              CPU_WE,
  input  logic [ADR_W-1:0]  CPU_ADR,
  input  logic [7:0]        CPU_DBO,
  output logic [7:0]        CPU_DBI,
  output logic              CPU_ACK,
  output logic [ADR_W-1:0]  MEM_ADR,
  output logic              MEM_OE,
  output logic              MEM_WE,
  output logic [7:0]        MEM_DBO,
  input  logic [7:0]        MEM_DBI,
  output slot_owner_t       dbg_state_o
);

  // Counter runs from issue until the capture clock, so it loads latency-1.
  localparam logic [1:0] LAT_LOAD = 2'(READ_LATENCY - 1);

  slot_owner_t      state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             rd_cpu_q, rd_cpu_d;
  logic [7:0]       pramdat_q, pramdat_d;
  logic [7:0]       cpu_dbi_q, cpu_dbi_d;
  logic             ack_q, ack_d;
  logic [ADR_W-1:0] mem_adr_q, mem_adr_d;
  logic             oe_q, oe_d;
  logic             we_q, we_d;
  logic [7:0]       dbo_q, dbo_d;
  logic             hold_q, hold_d;
  logic [2:0]       low_run_q, low_run_d;
  logic             low_dot, cpu_ok, slot_free;

  always_ff @(posedge CLK21M or posedge RESET) begin
    if (RESET) begin
      state_q   <= IDLE;
      cnt_q     <= 2'd0;
      rd_cpu_q  <= 1'b0;
      pramdat_q <= 8'd0;
      cpu_dbi_q <= 8'd0;
      ack_q     <= 1'b0;
      mem_adr_q <= '0;
      oe_q      <= 1'b0;
      we_q      <= 1'b0;
      dbo_q     <= 8'd0;
      hold_q    <= 1'b0;
      low_run_q <= 3'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_cpu_q  <= rd_cpu_d;
      pramdat_q <= pramdat_d;
      cpu_dbi_q <= cpu_dbi_d;
      ack_q     <= ack_d;
      mem_adr_q <= mem_adr_d;
      oe_q      <= oe_d;
      we_q      <= we_d;
      dbo_q     <= dbo_d;
      hold_q    <= hold_d;
      low_run_q <= low_run_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_cpu_d  = rd_cpu_q;
    pramdat_d = pramdat_q;
    cpu_dbi_d = cpu_dbi_q;
    ack_d     = 1'b0;
    mem_adr_d = mem_adr_q;
    oe_d      = 1'b0;
    we_d      = 1'b0;
    dbo_d     = dbo_q;
    slot_free = 1'b0;

    // Count consecutive clocks with CPU_REQ low; the fourth one completes a dot.
    low_run_d = CPU_REQ ? 3'd0 : ((low_run_q == 3'd4) ? 3'd4 : low_run_q + 3'd1);
    low_dot   = !CPU_REQ && (low_run_q >= 3'd3);
    hold_d    = hold_q && !low_dot;
    cpu_ok    = CPU_REQ && (!hold_q || low_dot);

    unique case (state_q)
      IDLE: slot_free = 1'b1;
      SP_RD, CPU_RD: begin
        state_d = WAIT;
        cnt_d   = LAT_LOAD;
      end
      CPU_WR: begin
        state_d = IDLE;
        ack_d   = 1'b1;
      end
      WAIT: begin
        if (cnt_q == 2'd0) begin
          state_d   = IDLE;
          slot_free = 1'b1;
          if (rd_cpu_q) begin
            cpu_dbi_d = MEM_DBI;
            ack_d     = 1'b1;
          end else begin
            pramdat_d = MEM_DBI;
          end
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A 3-cycle latency capture lands on the decision clock itself.
    if (slot_free && (DOTSTATE == DS_PH3)) begin
      if (SPVRAMACCESSING) begin
        state_d   = SP_RD;
        rd_cpu_d  = 1'b0;
        oe_d      = 1'b1;
        mem_adr_d = ADR_W'(vram_interleave(32'(PRAMADR), VRAMINTERLEAVEMODE, ADR_W));
      end else if (cpu_ok) begin
        hold_d    = 1'b1;
        mem_adr_d = ADR_W'(vram_interleave(32'(CPU_ADR), VRAMINTERLEAVEMODE, ADR_W));
        if (CPU_WE) begin
          state_d = CPU_WR;
          we_d    = 1'b1;
          dbo_d   = CPU_DBO;
        end else begin
          state_d  = CPU_RD;
          rd_cpu_d = 1'b1;
          oe_d     = 1'b1;
        end
      end
    end
  end

  assign PRAMDAT     = pramdat_q;
  assign CPU_DBI     = cpu_dbi_q;
  assign CPU_ACK     = ack_q;
  assign MEM_ADR     = mem_adr_q;
  assign MEM_OE      = oe_q;
  assign MEM_WE      = we_q;
  assign MEM_DBO     = dbo_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_vdp_vram_sprite_port.sv
// Directed bench for vdp_vram_sprite_port: a vector table of single-slot
// transactions plus hand sequences for sprite priority and reset mid-read.
module tb_vdp_vram_sprite_port;
  import vdp_vram_pkg::*;

  logic        CLK21M;
  logic        RESET;
  logic [1:0]  DOTSTATE;
  logic        VRAMINTERLEAVEMODE;
  logic        SPVRAMACCESSING;
  logic [16:0] PRAMADR;
  logic [7:0]  PRAMDAT;
  logic        CPU_REQ;
  logic        CPU_WE;
  logic [16:0] CPU_ADR;
  logic [7:0]  CPU_DBO;
  logic [7:0]  CPU_DBI;
  logic        CPU_ACK;
  logic [16:0] MEM_ADR;
  logic        MEM_OE;
  logic        MEM_WE;
  logic [7:0]  MEM_DBO;
  logic [7:0]  MEM_DBI;
  slot_owner_t dbg_state;

  vdp_vram_sprite_port #(.READ_LATENCY(2), .ADR_W(17)) dut (
    .CLK21M(CLK21M), .RESET(RESET), .DOTSTATE(DOTSTATE),
    .VRAMINTERLEAVEMODE(VRAMINTERLEAVEMODE), .SPVRAMACCESSING(SPVRAMACCESSING),
    .PRAMADR(PRAMADR), .PRAMDAT(PRAMDAT), .CPU_REQ(CPU_REQ), .CPU_WE(CPU_WE),
    .CPU_ADR(CPU_ADR), .CPU_DBO(CPU_DBO), .CPU_DBI(CPU_DBI), .CPU_ACK(CPU_ACK),
    .MEM_ADR(MEM_ADR), .MEM_OE(MEM_OE), .MEM_WE(MEM_WE), .MEM_DBO(MEM_DBO),
    .MEM_DBI(MEM_DBI), .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset / dot phase ----------------
  initial begin
    CLK21M = 1'b0;
    forever #5 CLK21M = ~CLK21M;
  end

  initial begin
    DOTSTATE = DS_PH0;
    forever begin
      @(posedge CLK21M);
      #1;
      case (DOTSTATE)
        DS_PH0:  DOTSTATE = DS_PH1;
        DS_PH1:  DOTSTATE = DS_PH2;
        DS_PH2:  DOTSTATE = DS_PH3;
        default: DOTSTATE = DS_PH0;
      endcase
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- external VRAM, 2-clock read latency ----------------
  logic [7:0] vram [0:131071];
  logic [7:0] pipe0, pipe1;
  assign MEM_DBI = pipe1;

  initial begin
    for (int i = 0; i < 131072; i++) vram[i] = 8'h00;
    vram[17'h03800] = 8'hFF;
    vram[17'h10F00] = 8'h3C;
    vram[17'h01E01] = 8'h77;
    vram[17'h1FFFF] = 8'h81;
    vram[17'h0FFFF] = 8'h42;
    vram[17'h1FFFE] = 8'h99;
    pipe0 = 8'hEE;
    pipe1 = 8'hEE;
    forever begin
      @(posedge CLK21M);
      if (MEM_WE) vram[MEM_ADR] <= MEM_DBO;
      pipe1 <= pipe0;
      pipe0 <= MEM_OE ? vram[MEM_ADR] : 8'hEE;
    end
  end

  // ---------------- scoreboard ----------------
  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  int         oe_n, we_n, ack_n;
  logic [7:0] ack_dbi;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK21M);
    #2;
    if (MEM_OE) oe_n++;
    if (MEM_WE) we_n++;
    if (CPU_ACK) begin
      ack_n++;
      ack_dbi = CPU_DBI;
    end
  endtask

  task automatic clr_cnt();
    oe_n = 0; we_n = 0; ack_n = 0; ack_dbi = 8'h00;
  endtask

  task automatic to_ph3();
    int k;
    k = 0;
    while (DOTSTATE != DS_PH3 && k < 8) begin
      tick();
      k++;
    end
    chk("align_ph3", 32'(DOTSTATE), 32'(DS_PH3));
  endtask

  task automatic idle_dot(input string name);
    SPVRAMACCESSING = 1'b0;
    CPU_REQ = 1'b0;
    clr_cnt();
    repeat (4) tick();
    chk({name, "_idle_strobes"}, 32'(oe_n + we_n), 32'd0);
    chk({name, "_idle_ack"}, 32'(ack_n), 32'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        mode;
    logic        sp;
    logic [16:0] sp_adr;
    logic        req;
    logic        we;
    logic [16:0] cpu_adr;
    logic [7:0]  cpu_dbo;
    logic [16:0] exp_adr;
    logic        exp_oe;
    logic        exp_we;
    logic [7:0]  exp_dbo;
    logic [7:0]  exp_pram;
    logic        exp_ack;
    logic [7:0]  exp_dbi;
  } vec_t;

  function automatic vec_t mk(input logic mode, input logic sp, input logic [16:0] sp_adr,
                              input logic req, input logic we, input logic [16:0] cpu_adr,
                              input logic [7:0] cpu_dbo, input logic [16:0] exp_adr,
                              input logic exp_oe, input logic exp_we, input logic [7:0] exp_dbo,
                              input logic [7:0] exp_pram, input logic exp_ack,
                              input logic [7:0] exp_dbi);
    vec_t v;
    v.mode = mode; v.sp = sp; v.sp_adr = sp_adr; v.req = req; v.we = we;
    v.cpu_adr = cpu_adr; v.cpu_dbo = cpu_dbo; v.exp_adr = exp_adr;
    v.exp_oe = exp_oe; v.exp_we = exp_we; v.exp_dbo = exp_dbo;
    v.exp_pram = exp_pram; v.exp_ack = exp_ack; v.exp_dbi = exp_dbi;
    return v;
  endfunction

  vec_t vecs[11];

  initial begin
    string nm;

    //            mode sp  sp_adr     req we cpu_adr    dbo    exp_adr    oe we exp_dbo pram   ack dbi
    vecs[0]  = mk(0,  1, 17'h03800, 0, 0, 17'h00000, 8'h00, 17'h03800, 1, 0, 8'h00, 8'hFF, 0, 8'h00);
    vecs[1]  = mk(1,  1, 17'h01E01, 0, 0, 17'h00000, 8'h00, 17'h10F00, 1, 0, 8'h00, 8'h3C, 0, 8'h00);
    vecs[2]  = mk(0,  0, 17'h00000, 1, 1, 17'h01C00, 8'h5A, 17'h01C00, 0, 1, 8'h5A, 8'h3C, 1, 8'h00);
    vecs[3]  = mk(0,  0, 17'h00000, 1, 0, 17'h01C00, 8'h00, 17'h01C00, 1, 0, 8'h00, 8'h3C, 1, 8'h5A);
    vecs[4]  = mk(1,  0, 17'h00000, 1, 1, 17'h00003, 8'hA5, 17'h10001, 0, 1, 8'hA5, 8'h3C, 1, 8'h00);
    vecs[5]  = mk(1,  0, 17'h00000, 1, 0, 17'h00003, 8'h00, 17'h10001, 1, 0, 8'h00, 8'h3C, 1, 8'hA5);
    vecs[6]  = mk(0,  1, 17'h1FFFF, 0, 0, 17'h00000, 8'h00, 17'h1FFFF, 1, 0, 8'h00, 8'h81, 0, 8'h00);
    vecs[7]  = mk(0,  0, 17'h00000, 0, 0, 17'h00000, 8'h00, 17'h1FFFF, 0, 0, 8'h00, 8'h81, 0, 8'h00);
    vecs[8]  = mk(1,  1, 17'h1FFFE, 0, 0, 17'h00000, 8'h00, 17'h0FFFF, 1, 0, 8'h00, 8'h42, 0, 8'h00);
    vecs[9]  = mk(0,  0, 17'h00000, 1, 0, 17'h10F00, 8'h00, 17'h10F00, 1, 0, 8'h00, 8'h42, 1, 8'h3C);
    vecs[10] = mk(1,  1, 17'h00003, 0, 0, 17'h00000, 8'h00, 17'h10001, 1, 0, 8'h00, 8'hA5, 0, 8'h00);

    RESET = 1'b1;
    VRAMINTERLEAVEMODE = 1'b0;
    SPVRAMACCESSING = 1'b0;
    PRAMADR = '0;
    CPU_REQ = 1'b0;
    CPU_WE = 1'b0;
    CPU_ADR = '0;
    CPU_DBO = '0;
    clr_cnt();

    repeat (3) @(posedge CLK21M);
    #2;
    chk("rst_pramdat", 32'(PRAMDAT), 32'd0);
    chk("rst_cpu_dbi", 32'(CPU_DBI), 32'd0);
    chk("rst_cpu_ack", 32'(CPU_ACK), 32'd0);
    chk("rst_mem_adr", 32'(MEM_ADR), 32'd0);
    chk("rst_strobes", 32'({MEM_OE, MEM_WE}), 32'd0);
    chk("rst_mem_dbo", 32'(MEM_DBO), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    RESET = 1'b0;
    to_ph3();

    // ---- table-driven single-slot transactions ----
    for (int i = 0; i < 11; i++) begin
      nm = $sformatf("v%0d", i);
      VRAMINTERLEAVEMODE = vecs[i].mode;
      SPVRAMACCESSING = vecs[i].sp;
      PRAMADR = vecs[i].sp_adr;
      CPU_REQ = vecs[i].req;
      CPU_WE = vecs[i].we;
      CPU_ADR = vecs[i].cpu_adr;
      CPU_DBO = vecs[i].cpu_dbo;
      exp_q.push_back(vecs[i].exp_pram);
      clr_cnt();
      tick();
      chk({nm, "_mem_adr"}, 32'(MEM_ADR), 32'(vecs[i].exp_adr));
      chk({nm, "_mem_oe"}, 32'(MEM_OE), 32'(vecs[i].exp_oe));
      chk({nm, "_mem_we"}, 32'(MEM_WE), 32'(vecs[i].exp_we));
      if (vecs[i].exp_we) chk({nm, "_mem_dbo"}, 32'(MEM_DBO), 32'(vecs[i].exp_dbo));
      SPVRAMACCESSING = 1'b0;
      PRAMADR = 17'h15555;
      CPU_ADR = 17'h0AAAA;
      repeat (3) tick();
      chk({nm, "_oe_count"}, 32'(oe_n), 32'(vecs[i].exp_oe));
      chk({nm, "_we_count"}, 32'(we_n), 32'(vecs[i].exp_we));
      chk({nm, "_pramdat"}, 32'(PRAMDAT), 32'(exp_q.pop_front()));
      chk({nm, "_ack_count"}, 32'(ack_n), 32'(vecs[i].exp_ack));
      if (vecs[i].exp_ack && !vecs[i].exp_we) chk({nm, "_cpu_dbi"}, 32'(ack_dbi), 32'(vecs[i].exp_dbi));
      idle_dot(nm);
    end

    // ---- CPU held off by three sprite slots, then served once ----
    VRAMINTERLEAVEMODE = 1'b0;
    CPU_REQ = 1'b1;
    CPU_WE = 1'b0;
    CPU_ADR = 17'h01C00;
    for (int d = 0; d < 3; d++) begin
      SPVRAMACCESSING = 1'b1;
      PRAMADR = 17'h03800;
      clr_cnt();
      tick();
      chk($sformatf("prio%0d_mem_adr", d), 32'(MEM_ADR), 32'h03800);
      repeat (3) tick();
      chk($sformatf("prio%0d_oe_count", d), 32'(oe_n), 32'd1);
      chk($sformatf("prio%0d_cpu_quiet", d), 32'(we_n + ack_n), 32'd0);
      chk($sformatf("prio%0d_pramdat", d), 32'(PRAMDAT), 32'hFF);
    end
    SPVRAMACCESSING = 1'b0;
    clr_cnt();
    tick();
    chk("prio_cpu_mem_adr", 32'(MEM_ADR), 32'h01C00);
    chk("prio_cpu_mem_oe", 32'(MEM_OE), 32'd1);
    repeat (3) tick();
    chk("prio_cpu_ack_count", 32'(ack_n), 32'd1);
    chk("prio_cpu_dbi", 32'(ack_dbi), 32'h5A);
    // REQ left high past ACK must not start a second access
    clr_cnt();
    repeat (4) tick();
    chk("held_req_strobes", 32'(oe_n + we_n), 32'd0);
    chk("held_req_ack", 32'(ack_n), 32'd0);
    idle_dot("after_held");
    idle_dot("settle");

    // ---- reset one clock after a CPU read issue ----
    CPU_REQ = 1'b1;
    CPU_WE = 1'b0;
    CPU_ADR = 17'h03800;
    clr_cnt();
    tick();
    chk("rstmid_issue_oe", 32'(MEM_OE), 32'd1);
    tick();
    RESET = 1'b1;
    CPU_REQ = 1'b0;
    #1;
    chk("rstmid_strobes", 32'({MEM_OE, MEM_WE, CPU_ACK}), 32'd0);
    chk("rstmid_outputs", 32'(MEM_ADR) | 32'(PRAMDAT) | 32'(CPU_DBI) | 32'(MEM_DBO), 32'd0);
    clr_cnt();
    tick();
    tick();
    RESET = 1'b0;
    to_ph3();
    chk("rstmid_no_ack", 32'(ack_n), 32'd0);
    idle_dot("rstmid");
    chk("rstmid_state", 32'(dbg_state), 32'(IDLE));
    chk("rstmid_cpu_dbi", 32'(CPU_DBI), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
